// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared definitions for the off-chip expansion bus bridge.
// Holds the bridge FSM states, the frame header layout and small byte helpers.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        WAIT,
        RDATA,
        DONE
    } state_e;

    localparam int HDR_START_BIT = 7;
    localparam int HDR_WE_BIT    = 0;
    localparam int HDR_SEL_MSB   = 4;
    localparam int HDR_SEL_LSB   = 1;
    localparam int HDR_ERR_BIT   = 0;

    localparam logic [7:0] IDLE_BYTE = 8'h00;

    localparam int WORD_BYTES = 4;

    // Builds the request header byte: start marker, byte selects and direction.
    function automatic logic [7:0] make_hdr(input logic we, input logic [3:0] sel);
        logic [7:0] hdr;
        hdr = IDLE_BYTE;
        hdr[HDR_START_BIT] = 1'b1;
        hdr[HDR_SEL_MSB:HDR_SEL_LSB] = sel;
        hdr[HDR_WE_BIT] = we;
        return hdr;
    endfunction

    // Picks byte idx of a 32-bit word, little-endian order.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/ext_bus_rx.sv
// ext_bus_rx: inbound side of the expansion bus bridge.
// Registers the inbound pads every clock, checks odd parity on the bytes the
// master consumes, flags response headers and assembles the 32-bit read word.
module ext_bus_rx
    import ext_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        wait_hdr,
    input  logic        rdata_phase,
    input  logic        clear,
    input  logic [7:0]  ib_data,
    input  logic        ib_pty,
    output logic        hdr_valid,
    output logic        hdr_err,
    output logic [31:0] data_word,
    output logic        data_valid,
    output logic        pty_err
);

    logic [7:0]  ib_data_q;
    logic        ib_pty_q;
    logic [31:0] data_word_q, data_word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        pty_err_q, pty_err_d;
    logic        byte_bad;
    logic        hdr_take;
    logic        data_take;
    logic [31:0] word_merge;

    // Classify the registered inbound byte and work out what gets consumed.
    always_comb begin
        byte_bad  = (ib_pty_q != ~^ib_data_q);
        hdr_take  = sample_en & wait_hdr & ib_data_q[HDR_START_BIT];
        data_take = sample_en & rdata_phase;

        word_merge = data_word_q;
        word_merge[8*byte_cnt_q +: 8] = ib_data_q;

        data_word_d = data_word_q;
        byte_cnt_d  = byte_cnt_q;
        pty_err_d   = pty_err_q;
        if (clear) begin
            byte_cnt_d = '0;
            pty_err_d  = 1'b0;
        end else begin
            if ((hdr_take | data_take) & byte_bad) begin
                pty_err_d = 1'b1;
            end
            if (data_take) begin
                data_word_d = word_merge;
                byte_cnt_d  = byte_cnt_q + 2'd1;
            end
        end
    end

    assign hdr_valid  = hdr_take;
    assign hdr_err    = ib_data_q[HDR_ERR_BIT];
    assign data_valid = data_take & (byte_cnt_q == 2'(WORD_BYTES - 1));
    assign data_word  = word_merge;
    assign pty_err    = pty_err_q | ((hdr_take | data_take) & byte_bad);

    // Inbound pad register plus the sticky parity flag and word assembly state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ib_data_q   <= IDLE_BYTE;
            ib_pty_q    <= 1'b1;
            data_word_q <= '0;
            byte_cnt_q  <= '0;
            pty_err_q   <= 1'b0;
        end else begin
            ib_data_q   <= ib_data;
            ib_pty_q    <= ib_pty;
            data_word_q <= data_word_d;
            byte_cnt_q  <= byte_cnt_d;
            pty_err_q   <= pty_err_d;
        end
    end

endmodule

// File: rtl/ext_bus_master.sv
// ext_bus_master: bridges one classic Wishbone transaction onto microwatt's
// byte-serial off-chip expansion bus and collects the response frame.
// Optional build macro EXT_BUS_TIMEOUT_EN: abandon a missing response header
// after TIMEOUT_CYCLES clocks and finish the cycle with wb_err.
module ext_bus_master
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W         = 30,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [3:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [31:0]       wb_dat_w,
    output logic [31:0]       wb_dat_r,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              oib_clk,
    output logic [7:0]        ob_data,
    output logic              ob_pty,
    input  logic [7:0]        ib_data,
    input  logic              ib_pty
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ext_bus_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic        oib_clk_q;
    logic [7:0]  ob_data_q, ob_data_d;
    logic [1:0]  tx_cnt_q, tx_cnt_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rem_err_q, rem_err_d;
    logic        cyc_lost_q, cyc_lost_d;
    logic [31:0] dat_r_q, dat_r_d;

    logic        beat;
    logic        hdr_valid;
    logic        hdr_err;
    logic [31:0] data_word;
    logic        data_valid;
    logic        pty_err;
    logic        timeout_hit;
    logic        fail;
    logic        done_live;

    // A beat is the cycle in which the forwarded clock is about to fall; the
    // inbound byte captured on its rising edge is also evaluated in this cycle.
    assign beat = oib_clk_q;

    ext_bus_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (oib_clk_q),
        .wait_hdr    (state_q == WAIT),
        .rdata_phase (state_q == RDATA),
        .clear       (state_q == IDLE),
        .ib_data     (ib_data),
        .ib_pty      (ib_pty),
        .hdr_valid   (hdr_valid),
        .hdr_err     (hdr_err),
        .data_word   (data_word),
        .data_valid  (data_valid),
        .pty_err     (pty_err)
    );

`ifdef EXT_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Count clocks spent waiting for a response header; restart on every entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == WAIT) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign fail      = rem_err_q | pty_err;
    assign done_live = (state_q == DONE) && !cyc_lost_q && wb_cyc;

    // Next-state, transmit byte and request latching for the bridge FSM.
    always_comb begin
        state_d    = state_q;
        ob_data_d  = ob_data_q;
        tx_cnt_d   = tx_cnt_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rem_err_d  = rem_err_q;
        cyc_lost_d = cyc_lost_q;
        dat_r_d    = dat_r_q;

        if ((state_q != IDLE) && !wb_cyc) begin
            cyc_lost_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cyc_lost_d = 1'b0;
                rem_err_d  = 1'b0;
                if (beat) begin
                    ob_data_d = IDLE_BYTE;
                end
                if (wb_cyc && wb_stb) begin
                    we_d  = wb_we;
                    sel_d = wb_sel;
                    adr_d = '0;
                    adr_d[ADDR_W-1:0] = wb_adr;
                    dat_d = wb_dat_w;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (beat) begin
                    ob_data_d = make_hdr(we_q, sel_q);
                    tx_cnt_d  = '0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (beat) begin
                    ob_data_d = word_byte(adr_q, tx_cnt_q);
                    tx_cnt_d  = tx_cnt_q + 2'd1;
                    if (tx_cnt_q == 2'(WORD_BYTES - 1)) begin
                        state_d = we_q ? DATA : WAIT;
                    end
                end
            end
            DATA: begin
                if (beat) begin
                    ob_data_d = word_byte(dat_q, tx_cnt_q);
                    tx_cnt_d  = tx_cnt_q + 2'd1;
                    if (tx_cnt_q == 2'(WORD_BYTES - 1)) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (beat) begin
                    ob_data_d = IDLE_BYTE;
                end
                if (hdr_valid) begin
                    rem_err_d = hdr_err;
                    state_d   = (!we_q && !hdr_err) ? RDATA : DONE;
                end else if (timeout_hit) begin
                    rem_err_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RDATA: begin
                if (beat) begin
                    ob_data_d = IDLE_BYTE;
                end
                if (data_valid) begin
                    state_d = DONE;
                    if (!rem_err_q && !pty_err && !cyc_lost_q && wb_cyc) begin
                        dat_r_d = data_word;
                    end
                end
            end
            DONE: begin
                if (beat) begin
                    ob_data_d = IDLE_BYTE;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bridge state, forwarded bus clock and transmit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            oib_clk_q  <= 1'b0;
            ob_data_q  <= IDLE_BYTE;
            tx_cnt_q   <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rem_err_q  <= 1'b0;
            cyc_lost_q <= 1'b0;
            dat_r_q    <= '0;
        end else begin
            state_q    <= state_d;
            oib_clk_q  <= ~oib_clk_q;
            ob_data_q  <= ob_data_d;
            tx_cnt_q   <= tx_cnt_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rem_err_q  <= rem_err_d;
            cyc_lost_q <= cyc_lost_d;
            dat_r_q    <= dat_r_d;
        end
    end

    assign oib_clk  = oib_clk_q;
    assign ob_data  = ob_data_q;
    assign ob_pty   = ~^ob_data_q;
    assign wb_dat_r = dat_r_q;
    assign wb_ack   = done_live && !fail;
    assign wb_err   = done_live && fail;

endmodule

// File: tb/tb_ext_bus_master.sv
// tb_ext_bus_master: directed scoreboard bench for ext_bus_master.
// Expected outbound bytes and Wishbone responses are queued when a request is
// driven and popped as the bridge produces them. Honours EXT_BUS_TIMEOUT_EN.
module tb_ext_bus_master;

    logic        clk;
    logic        rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        oib_clk;
    logic [7:0]  ob_data;
    logic        ob_pty;
    logic [7:0]  ib_data;
    logic        ib_pty;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic [7:0]  exp_ob_q[$];
    resp_t       exp_resp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_oib = 1'b0;
    logic [31:0] model_dat_r = 32'h0;

    ext_bus_master #(
        .ADDR_W         (30),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .oib_clk  (oib_clk),
        .ob_data  (ob_data),
        .ob_pty   (ob_pty),
        .ib_data  (ib_data),
        .ib_pty   (ib_pty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic boundExpired(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed=no event expected=event within bound", tag);
    endtask

    task automatic waitBeat();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (prev_oib && !oib_clk) found = 1'b1;
            prev_oib = oib_clk;
        end
        if (!found) boundExpired("beat_timeout");
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                                 input logic [31:0] dat, input logic exp_ack,
                                 input logic exp_err, input logic [31:0] exp_dat);
        logic [31:0] adr_ext;
        resp_t       r;
        @(negedge clk);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_sel   = sel;
        wb_adr   = adr;
        wb_dat_w = dat;
        adr_ext  = {2'b00, adr};
        exp_ob_q.push_back({1'b1, 2'b00, sel, we});
        for (int i = 0; i < 4; i++) exp_ob_q.push_back(adr_ext[8*i +: 8]);
        if (we) begin
            for (int i = 0; i < 4; i++) exp_ob_q.push_back(dat[8*i +: 8]);
        end
        r.ack = exp_ack;
        r.err = exp_err;
        r.dat = exp_dat;
        exp_resp_q.push_back(r);
        @(posedge clk);
        #1;
        prev_oib = oib_clk;
    endtask

    task automatic checkFrame();
        logic [7:0] e;
        while (exp_ob_q.size() > 0) begin
            waitBeat();
            e = exp_ob_q.pop_front();
            checkOutput("ob_data", 32'(ob_data), 32'(e));
            checkOutput("ob_pty", 32'(ob_pty), 32'(~^e));
        end
    endtask

    task automatic respond(input logic [7:0] bytes [5], input int n, input int flip_idx);
        for (int i = 0; i < n; i++) begin
            waitBeat();
            ib_data = bytes[i];
            ib_pty  = (~^bytes[i]) ^ (i == flip_idx);
        end
        waitBeat();
        ib_data = 8'h00;
        ib_pty  = 1'b1;
    endtask

    task automatic checkResponse(input string tag);
        resp_t r;
        bit    seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (wb_ack || wb_err) seen = 1'b1;
            else @(negedge clk);
        end
        r = exp_resp_q.pop_front();
        if (!seen) begin
            boundExpired({tag, "_done"});
        end else begin
            checkOutput({tag, "_ack"}, 32'(wb_ack), 32'(r.ack));
            checkOutput({tag, "_err"}, 32'(wb_err), 32'(r.err));
            checkOutput({tag, "_dat_r"}, wb_dat_r, r.dat);
            wb_stb = 1'b0;
            @(negedge clk);
            checkOutput({tag, "_pulse"}, 32'({wb_ack, wb_err}), 32'h0);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
    endtask

    initial begin
        int  k;
        bit  seen;
        logic [7:0] e;

        rst      = 1'b1;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_sel   = 4'h0;
        wb_adr   = '0;
        wb_dat_w = '0;
        ib_data  = 8'h00;
        ib_pty   = 1'b1;
        $display("[TB] start");

        repeat (3) @(negedge clk);
        checkOutput("rst_oib_clk", 32'(oib_clk), 32'h0);
        checkOutput("rst_ob_data", 32'(ob_data), 32'h0);
        checkOutput("rst_ob_pty", 32'(ob_pty), 32'h1);
        checkOutput("rst_ack", 32'(wb_ack), 32'h0);
        checkOutput("rst_err", 32'(wb_err), 32'h0);
        checkOutput("rst_dat_r", wb_dat_r, 32'h0);
        rst = 1'b0;

        $display("[TB] write 0x1234");
        applyStimulus(1'b1, 4'hF, 30'h1234, 32'hDEADBEEF, 1'b1, 1'b0, model_dat_r);
        checkFrame();
        respond('{8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 1, -1);
        checkResponse("wr1");

        $display("[TB] read 0x10");
        model_dat_r = 32'h12345678;
        applyStimulus(1'b0, 4'hF, 30'h10, 32'h0, 1'b1, 1'b0, model_dat_r);
        checkFrame();
        respond('{8'h80, 8'h78, 8'h56, 8'h34, 8'h12}, 5, -1);
        checkResponse("rd1");

        $display("[TB] read with remote error header");
        applyStimulus(1'b0, 4'h5, 30'h3FFF_FFFF, 32'h0, 1'b0, 1'b1, model_dat_r);
        checkFrame();
        respond('{8'h81, 8'h00, 8'h00, 8'h00, 8'h00}, 1, -1);
        checkResponse("rd_remerr");

        $display("[TB] read with bad parity on data byte 2");
        applyStimulus(1'b0, 4'hF, 30'h20, 32'h0, 1'b0, 1'b1, model_dat_r);
        checkFrame();
        respond('{8'h80, 8'h11, 8'h22, 8'h33, 8'h44}, 5, 3);
        checkResponse("rd_pty");

        $display("[TB] reset during address byte 1");
        applyStimulus(1'b1, 4'h3, 30'h55AA, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            waitBeat();
            e = exp_ob_q.pop_front();
            checkOutput("rst_pre_ob_data", 32'(ob_data), 32'(e));
        end
        rst    = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ob_data", 32'(ob_data), 32'h0);
        checkOutput("midrst_ob_pty", 32'(ob_pty), 32'h1);
        checkOutput("midrst_oib_clk", 32'(oib_clk), 32'h0);
        checkOutput("midrst_dat_r", wb_dat_r, 32'h0);
        exp_ob_q.delete();
        exp_resp_q.delete();
        model_dat_r = 32'h0;
        rst = 1'b0;

        $display("[TB] write after reset");
        applyStimulus(1'b1, 4'h3, 30'h0ABC, 32'hCAFE0001, 1'b1, 1'b0, model_dat_r);
        checkFrame();
        respond('{8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 1, -1);
        checkResponse("wr2");

        $display("[TB] read after reset");
        model_dat_r = 32'h89ABCDEF;
        applyStimulus(1'b0, 4'hF, 30'h0ABC, 32'h0, 1'b1, 1'b0, model_dat_r);
        checkFrame();
        respond('{8'h80, 8'hEF, 8'hCD, 8'hAB, 8'h89}, 5, -1);
        checkResponse("rd2");

        $display("[TB] read with no response");
        applyStimulus(1'b0, 4'hF, 30'h40, 32'h0, 1'b0, 1'b1, model_dat_r);
        checkFrame();
`ifdef EXT_BUS_TIMEOUT_EN
        k = 0;
        while (!(wb_ack || wb_err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("timeout_clks", 32'(k), 32'd16);
        checkOutput("timeout_err", 32'(wb_err), 32'h1);
        checkOutput("timeout_ack", 32'(wb_ack), 32'h0);
        checkOutput("timeout_dat_r", wb_dat_r, model_dat_r);
`else
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (wb_ack || wb_err) seen = 1'b1;
        end
        checkOutput("no_timeout_done", 32'(seen), 32'h0);
        checkOutput("no_timeout_dat_r", wb_dat_r, model_dat_r);
`endif
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        exp_resp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
